// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage of the RV32I core. Owns the program counter, drives
//   the instruction-memory address and registers each fetched word together
//   with its PC into a single valid/ready slot feeding decode. Branch redirects
//   from execute (branch_pc + ImmOp) reload the PC and flush the slot; a
//   misaligned redirect target halts fetching until reset.
//
// Ports
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   imem_addr    out  WIDTH  instruction-memory address (combinational = PC)
//   imem_rdata   in   WIDTH  instruction word at imem_addr (same-cycle read)
//   branch_taken in   1      redirect request from execute
//   branch_pc    in   WIDTH  PC of the redirecting instruction
//   ImmOp        in   WIDTH  sign-extended branch offset
//   instr        out  WIDTH  registered instruction to decode
//   instr_pc     out  WIDTH  PC of instr
//   instr_valid  out  1      instr/instr_pc hold a live instruction
//   instr_ready  in   1      decode accepts this cycle
//   misalign     out  1      sticky: last redirect target was misaligned
//   fetch_count  out  32     instructions accepted by decode since reset
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          WIDTH    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_pc,
  input  logic [WIDTH-1:0] ImmOp,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic             misalign,
  output logic [31:0]      fetch_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_TRAP = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic             valid_q, valid_d;
  logic             misalign_q, misalign_d;
  logic [31:0]      count_q, count_d;

  logic             slot_free_s;
  logic             xfer_s;
  logic [WIDTH-1:0] target_s;

  // Handshake qualifiers and redirect target (modulo 2^WIDTH).
  assign slot_free_s = !valid_q || instr_ready;
  assign xfer_s      = valid_q && instr_ready;
  assign target_s    = branch_pc + ImmOp;

  // Next-state logic: FSM plus slot/PC update with redirect > fetch > stall.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;
    // A word accepted on a redirect edge is flushed but still counted.
    count_d    = xfer_s ? (count_q + 32'd1) : count_q;

    case (state_q)
      ST_IDLE: begin
        // One idle cycle after reset gives memory time to present RESET_PC.
        state_d = ST_RUN;
        valid_d = 1'b0;
      end
      ST_RUN: begin
        if (branch_taken) begin
          valid_d = 1'b0;
          pc_d    = target_s;
          if (target_s[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = ST_TRAP;
          end else begin
            state_d = ST_RUN;
          end
        end else if (slot_free_s) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          pc_d       = pc_q + PC_STEP;
        end else begin
          // Stall: decode has not taken the current word; hold everything.
          pc_d    = pc_q;
          valid_d = valid_q;
        end
      end
      ST_TRAP: begin
        // Halted on a misaligned target; only reset leaves this state.
        valid_d = 1'b0;
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC[WIDTH-1:0];
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign misalign    = misalign_q;
  assign fetch_count = count_q;

endmodule
